inst_mem_ctrl: RTL
==================

# inst_mem_ctrl

Parametrised instruction memory for the processor fetch stage, replacing the fixed 32-byte, reset-initialised combinational ROM. It holds a word-organised array loaded at run time through a loader port. It clears itself to NOPs after reset and serves fetches with a registered one-cycle latency. Misaligned and out-of-range program counters are flagged.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, ≥ 4.
- `PC_W`, 32: width of `fetch_pc`.
- `AW`, derived as `$clog2(DEPTH)`: width of the word index.
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: synchronous, active-low.
- `load_valid` in 1: loader word present.
- `load_ready` out 1: loader word accepted this cycle when `load_valid & load_ready`.
- `load_addr` in `PC_W`: byte address of the word; bits [1:0] ignored.
- `load_data` in 32: instruction word.
- `load_last` in 1: final word of the program.
- `load_err` out 1: sticky; a loader word was out of range.
- `reload` in 1: return from RUN to LOAD. Memory is not cleared.
- `fetch_req` in 1: fetch request.
- `fetch_ready` out 1: high only in RUN.
- `fetch_pc` in `PC_W`: byte address.
- `inst_valid` out 1: result valid, one cycle after an accepted fetch.
- `inst_code` out 32: instruction word.
- `inst_fault` out 2: 00 none, 01 misaligned, 10 out of range.

## Operation
- States are CLEAR, LOAD and RUN.
- **CLEAR:** entered on reset.
  - A word counter runs from 0 to `DEPTH`-1 and writes 32'h00000013 (NOP) to each word.
  - `load_ready` = 0 and `fetch_ready` = 0.
  - After word `DEPTH`-1 is written, the next state is LOAD.
- **LOAD:**
  - `load_ready` = 1.
  - On an accepted word, if `load_addr >> 2` < `DEPTH`, `load_data` is written to that word.
  - If the index is ≥ `DEPTH`, the write is dropped and `load_err` is set.
  - An accepted word with `load_last` = 1 moves the state to RUN, whether or not that word is in range.
  - `fetch_req` is ignored.
- **RUN:**
  - `fetch_ready` = 1.
  - An accepted fetch registers its result for the next cycle.
  - Fetches may be accepted every cycle (fully pipelined), with no back-pressure.
  - If `fetch_pc[1:0]` ≠ 0, the result is `inst_code` = NOP and `inst_fault` = 01.
  - Otherwise, if the word index is ≥ `DEPTH` (including any nonzero `fetch_pc` bits above `AW`+1), the result is NOP with `inst_fault` = 10.
  - Otherwise the result is the stored word with `inst_fault` = 00.
  - `reload` = 1 moves the state to LOAD.
- **Byte order:** little-endian. Byte address 4k+0 maps to `inst_code[7:0]`, and 4k+3 maps to [31:24]. This matches the existing fetch/decode byte order.
- `load_err` clears only on reset.

## Timing
- **Reset values** while `reset` = 0 is sampled:
  - state = CLEAR, counter = 0.
  - `load_ready` = 0, `fetch_ready` = 0, `inst_valid` = 0.
  - `inst_code` = 32'h00000013, `inst_fault` = 00, `load_err` = 0.
- **Ready/state alignment:** the first LOAD cycle begins exactly `DEPTH` cycles after `reset` deasserts. `load_ready` and `fetch_ready` are registered and match the current state.
- **Fetch latency:** `inst_valid` is high in cycle t+1 if and only if a fetch was accepted in cycle t. `inst_code` and `inst_fault` hold their last values when `inst_valid` = 0.
- **Load to RUN:** a word accepted with `load_last` is written at that edge. RUN starts the next cycle, and a fetch there returns that word.
- **Reload with a fetch:** if `reload` and an accepted fetch occur in the same cycle, the fetch still completes the next cycle. `fetch_ready` is 0 from the next cycle onward.
- **Reload outside RUN:** `reload` in CLEAR or LOAD is ignored.
- **Same-cycle load and fetch:** cannot occur, because the two ready signals are mutually exclusive.
- **Reset mid-operation:** an in-flight fetch is discarded, so `inst_valid` = 0 in the following cycle. Any load in progress is abandoned, and CLEAR restarts from word 0.

## Structure
- **Package `inst_mem_pkg`** contains:
  - state enum {CLEAR, LOAD, RUN};
  - `NOP_INSN` = 32'h00000013;
  - fault codes `FLT_NONE`, `FLT_MISALIGN`, `FLT_RANGE`.
- **Sub-module `inst_mem_ram`:**
  - `DEPTH` × 32, one write port, one synchronous read port, no reset on the array.
  - The write port is muxed between the CLEAR counter and the loader.
  - Fault and NOP substitution are applied after the read, using the registered fault code.

## Test plan
- **Clear:** `DEPTH`=8, release reset, fetch 0x0..0x1C after RUN.
  - To reach RUN, load a single word 0x0 = 0x00502023 with `load_last`.
  - Required: `load_ready` rises 8 cycles after reset release.
  - Required: 0x0 returns 0x00502023 and every other address returns 0x00000013 with fault 00.
- **Load/fetch:** load 0x0 = 0x00502023, 0x4 = 0x00002303, 0x8 = 0x000303B3 (last).
  - Then issue back-to-back fetches of 0x0, 0x4 and 0x8 on consecutive cycles.
  - Required: those three words, each one cycle later, with `inst_valid` high for 3 consecutive cycles.
- **Faults:**
  - Fetch 0x2: required NOP with fault 01.
  - Fetch 4·`DEPTH`: required NOP with fault 10.
  - Load to 4·`DEPTH`: required `load_err` = 1 and memory unchanged.
- **Reload:**
  - In RUN, assert `reload` in the same cycle as a fetch of 0x4. Required: that result is delivered and `fetch_ready` is 0 next cycle.
  - Then load 0x4 = 0x01BD5F33 (last) and fetch 0x4. Required: 0x01BD5F33, with other words preserved.
- **Reset mid-op:**
  - Assert `reset` = 0 for 1 cycle during LOAD, and again with a fetch in flight.
  - Required: `inst_valid` = 0 next cycle, `load_err` = 0, and a full `DEPTH`-cycle CLEAR that leaves all words NOP.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the run-time loadable instruction memory.
// Imported by the RAM macro wrapper, the controller top and the bench.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  localparam logic [1:0]  FLT_NONE     = 2'b00;
  localparam logic [1:0]  FLT_MISALIGN = 2'b01;
  localparam logic [1:0]  FLT_RANGE    = 2'b10;

  // Misalignment takes priority over range so a bad low-order PC is reported as such.
  function automatic logic [1:0] fetch_fault(input logic misaligned, input logic out_of_range);
    if (misaligned)
      return FLT_MISALIGN;
    else if (out_of_range)
      return FLT_RANGE;
    else
      return FLT_NONE;
  endfunction

endpackage

// File: rtl/inst_mem_ram.sv
// DEPTH x 32 word array with one write port and one registered read port.
// The array itself has no reset; only the read register returns to NOP.
module inst_mem_ram
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  // Read register holds its value between reads so the fetch output stays stable.
  always_ff @(posedge clk) begin
    if (!reset)
      rdata_q <= NOP_INSN;
    else if (re)
      rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: clears the array to NOPs after reset, accepts a
// program through the loader port, then serves pipelined one-cycle fetches.
module inst_mem_ctrl
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PC_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [PC_W-1:0] load_addr,
  input  logic [31:0]     load_data,
  input  logic            load_last,
  output logic            load_err,
  input  logic            reload,
  input  logic            fetch_req,
  output logic            fetch_ready,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            inst_valid,
  output logic [31:0]     inst_code,
  output logic [1:0]      inst_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    fault_q;

  logic          load_acc;
  logic          fetch_acc;
  logic          load_in_range;
  logic          fetch_out_of_range;
  logic          fetch_misaligned;
  logic [1:0]    fetch_flt;
  logic [PC_W-1:0] load_widx;
  logic [PC_W-1:0] fetch_widx;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic          ram_re;
  logic [31:0]   ram_rdata;

  // Handshakes; the two ready flags are never high together.
  assign load_acc  = load_valid & load_ready;
  assign fetch_acc = fetch_req & fetch_ready;

  // Address decode: any word index at or above DEPTH, including high PC bits, is out of range.
  assign load_widx          = load_addr >> 2;
  assign fetch_widx         = fetch_pc >> 2;
  assign load_in_range      = (load_widx < DEPTH_PC);
  assign fetch_out_of_range = (fetch_widx >= DEPTH_PC);
  assign fetch_misaligned   = (fetch_pc[1:0] != 2'b00);
  assign fetch_flt          = fetch_fault(fetch_misaligned, fetch_out_of_range);

  // Next-state and write-port mux between the clear counter and the loader.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = cnt_q;
    ram_wdata = NOP_INSN;

    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = NOP_INSN;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX)
          state_d = LOAD;
      end
      LOAD: begin
        if (load_acc) begin
          ram_we    = load_in_range;
          ram_waddr = load_addr[AW+1:2];
          ram_wdata = load_data;
          if (load_last)
            state_d = RUN;
        end
      end
      RUN: begin
        if (reload)
          state_d = LOAD;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Faulting fetches skip the array read; NOP is substituted at the output.
  assign ram_re = fetch_acc & (fetch_flt == FLT_NONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      load_ready  <= 1'b0;
      fetch_ready <= 1'b0;
      inst_valid  <= 1'b0;
      fault_q     <= FLT_NONE;
      load_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_ready  <= (state_d == LOAD);
      fetch_ready <= (state_d == RUN);
      inst_valid  <= fetch_acc;
      if (fetch_acc)
        fault_q <= fetch_flt;
      if (load_acc && !load_in_range)
        load_err <= 1'b1;
    end
  end

  inst_mem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_pc[AW+1:2]),
    .rdata (ram_rdata)
  );

  // Registered fault code selects between the read register and NOP.
  assign inst_code  = (fault_q == FLT_NONE) ? ram_rdata : NOP_INSN;
  assign inst_fault = fault_q;

endmodule
